// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine for circular, linear and hyperbolic modes.
// It does one micro-rotation per clock and uses valid/ready handshakes on both sides.
// state | meaning
// IDLE  | waiting for operands
// RUN   | one micro-rotation per clock
// DONE  | results held until out_ready
module cordic_iter_engine #(
  parameter int WHOLE_BIT_WIDTH   = 4,
  parameter int DECIMAL_BIT_WIDTH = 12,
  parameter int BIT_WIDTH         = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH,
  parameter int ITERATIONS        = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] x_in,
  input  logic signed [BIT_WIDTH-1:0] y_in,
  input  logic signed [BIT_WIDTH-1:0] z_in,
  input  logic                        mode_bit,
  input  logic [1:0]                  coordinate_system,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] x_out,
  output logic signed [BIT_WIDTH-1:0] y_out,
  output logic signed [BIT_WIDTH-1:0] z_out,
  output logic                        out_ovf,
  output logic                        out_err,
  output logic                        busy
);
  localparam int BW = BIT_WIDTH;
  localparam int SW = $clog2(ITERATIONS + 2);
  localparam int KW = SW + 2;
  localparam int TF = 60;
  localparam logic [1:0] CIRC = 2'b00, LIN = 2'b01, HYP = 2'b10, RSVD = 2'b11;
  localparam logic [SW-1:0] LAST_CL = SW'(ITERATIONS - 1);
  localparam logic [SW-1:0] LAST_HY = SW'(ITERATIONS);

  // Taylor series of atan/atanh(2^-s) at TF fractional bits, elaboration only
  function automatic longint series(input int s, input bit alt);
    longint acc, term;
    acc = 0;
    for (int n = 0; s * (2 * n + 1) < TF; n++) begin
      term = (longint'(1) <<< (TF - s * (2 * n + 1))) / (2 * n + 1);
      acc = (alt && (n % 2 == 1)) ? acc - term : acc + term;
    end
    return acc;
  endfunction

  function automatic logic [BW-1:0] e_fix(input int sys, input int s);
    longint v;
    if (sys == 1) v = longint'(1) <<< (TF - s);
    else if (s == 0) v = (sys == 0) ? 64'h0C90FDAA22168C23 : 64'd0;
    else v = series(s, sys == 0);
    v = (v + (longint'(1) <<< (TF - 1 - DECIMAL_BIT_WIDTH))) >>> (TF - DECIMAL_BIT_WIDTH);
    return v[BW-1:0];
  endfunction

  logic [BW-1:0] atan_tab  [2**SW];
  logic [BW-1:0] lin_tab   [2**SW];
  logic [BW-1:0] atanh_tab [2**SW];

  for (genvar i = 0; i < 2**SW; i++) begin : g_tab
    localparam logic [BW-1:0] E_ATAN  = e_fix(0, i);
    localparam logic [BW-1:0] E_LIN   = e_fix(1, i);
    localparam logic [BW-1:0] E_ATANH = e_fix(2, i);
    assign atan_tab[i]  = E_ATAN;
    assign lin_tab[i]   = E_LIN;
    assign atanh_tab[i] = E_ATANH;
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic signed [BW-1:0] x_q, y_q, z_q, xs, ys;
  logic [BW-1:0] e_cur;
  logic [BW:0] x_nx, y_nx, z_nx;
  logic [SW-1:0] shift_q;
  logic [KW-1:0] rep_k_q;
  logic rep_done_q, mode_q, ovf_q, err_q;
  logic [1:0] sys_q;
  logic d_pos, x_sub, step_ovf, hyp_rep, last_step, accept;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;

  // hyperbolic repeat: the first visit of index rep_k is executed once more
  assign hyp_rep   = (sys_q == HYP) && ({2'b00, shift_q} == rep_k_q) && !rep_done_q;
  assign last_step = (sys_q == HYP) ? ((shift_q == LAST_HY) && !hyp_rep) : (shift_q == LAST_CL);

  always_comb begin
    xs = x_q >>> shift_q;
    ys = y_q >>> shift_q;
    case (sys_q)
      CIRC:    e_cur = atan_tab[shift_q];
      LIN:     e_cur = lin_tab[shift_q];
      default: e_cur = atanh_tab[shift_q];
    endcase
    d_pos = mode_q ? y_q[BW-1] : ~z_q[BW-1];
    x_sub = (sys_q == CIRC) ? d_pos : ~d_pos;
    if (sys_q == LIN) x_nx = {x_q[BW-1], x_q};
    else if (x_sub)   x_nx = {x_q[BW-1], x_q} - {ys[BW-1], ys};
    else              x_nx = {x_q[BW-1], x_q} + {ys[BW-1], ys};
    y_nx = d_pos ? {y_q[BW-1], y_q} + {xs[BW-1], xs} : {y_q[BW-1], y_q} - {xs[BW-1], xs};
    z_nx = d_pos ? {z_q[BW-1], z_q} - {e_cur[BW-1], e_cur} : {z_q[BW-1], z_q} + {e_cur[BW-1], e_cur};
    step_ovf = (x_nx[BW] ^ x_nx[BW-1]) | (y_nx[BW] ^ y_nx[BW-1]) | (z_nx[BW] ^ z_nx[BW-1]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (coordinate_system == RSVD) ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      mode_q     <= 1'b0;
      sys_q      <= CIRC;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      shift_q    <= '0;
      rep_k_q    <= KW'(4);
      rep_done_q <= 1'b0;
    end else if (accept) begin
      x_q        <= x_in;
      y_q        <= y_in;
      z_q        <= z_in;
      mode_q     <= mode_bit;
      sys_q      <= coordinate_system;
      ovf_q      <= 1'b0;
      err_q      <= (coordinate_system == RSVD);
      shift_q    <= (coordinate_system == HYP) ? SW'(1) : '0;
      rep_k_q    <= KW'(4);
      rep_done_q <= 1'b0;
    end else if (state_q == RUN) begin
      x_q   <= x_nx[BW-1:0];
      y_q   <= y_nx[BW-1:0];
      z_q   <= z_nx[BW-1:0];
      ovf_q <= ovf_q | step_ovf;
      if (hyp_rep) begin
        rep_done_q <= 1'b1;
      end else begin
        shift_q <= shift_q + SW'(1);
        if ({2'b00, shift_q} == rep_k_q) begin
          rep_k_q    <= rep_k_q + {rep_k_q[KW-2:0], 1'b0} + KW'(1);
          rep_done_q <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: the driver pushes bit-true and hand-derived
// expectations, and the monitor checks each result when out_valid rises.
module tb_cordic_iter_engine;
  localparam int BW = 16;
  localparam int IT = 14;
  localparam logic [1:0] CIRC = 2'b00, LIN = 2'b01, HYP = 2'b10, RSVD = 2'b11;

  typedef struct {
    logic signed [15:0] x, y, z;
    logic ovf, err;
    int steps, exp_cyc, hold;
    int rx, ry, rz, tx, ty, tz, rovf;
  } exp_t;

  logic clk = 0, rst = 1, in_valid = 0, mode_bit = 0, out_ready = 0;
  logic in_ready, out_valid, out_ovf, out_err, busy;
  logic [1:0] coordinate_system = 2'b00;
  logic signed [BW-1:0] x_in = 0, y_in = 0, z_in = 0;
  logic signed [BW-1:0] x_out, y_out, z_out;

  int checks = 0, errors = 0, cyc = 0, n_pushed = 0, n_done = 0, hold_left = 0;
  bit seen = 0;
  exp_t sb[$];
  exp_t me;

  cordic_iter_engine #(
    .WHOLE_BIT_WIDTH(4), .DECIMAL_BIT_WIDTH(12), .BIT_WIDTH(BW), .ITERATIONS(IT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .mode_bit(mode_bit),
    .coordinate_system(coordinate_system), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .out_ovf(out_ovf), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int got, input int ref_v, input int tol);
    int diff;
    diff = got - ref_v;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d +-%0d", name, got, ref_v, tol);
    end
  endtask

  function automatic int etab(input int sys, input int s);
    real p, v;
    p = 1.0;
    for (int i = 0; i < s; i++) p = p / 2.0;
    if (sys == 0)      v = $atan(p);
    else if (sys == 1) v = p;
    else               v = 0.5 * $ln((1.0 + p) / (1.0 - p));
    return $rtoi($floor(v * 4096.0 + 0.5));
  endfunction

  task automatic model(input logic signed [15:0] xi, yi, zi, input logic md,
                       input logic [1:0] sys, output exp_t e);
    int sh[$];
    logic signed [15:0] x, y, z;
    int xn, yn, zn, xs, ys, ev;
    bit dp, ov;
    x = xi; y = yi; z = zi; ov = 0;
    if (sys == RSVD) begin
      e.x = xi; e.y = yi; e.z = zi; e.ovf = 0; e.err = 1; e.steps = 0;
      return;
    end
    if (sys == HYP) begin
      for (int k = 1; k <= IT; k++) begin
        sh.push_back(k);
        if (k == 4 || k == 13 || k == 40) sh.push_back(k);
      end
    end else begin
      for (int k = 0; k < IT; k++) sh.push_back(k);
    end
    foreach (sh[i]) begin
      xs = int'(x >>> sh[i]);
      ys = int'(y >>> sh[i]);
      ev = etab(int'(sys), sh[i]);
      dp = md ? y[15] : !z[15];
      if (sys == LIN) xn = x;
      else if ((sys == CIRC) == dp) xn = int'(x) - ys;
      else xn = int'(x) + ys;
      yn = dp ? int'(y) + xs : int'(y) - xs;
      zn = dp ? int'(z) - ev : int'(z) + ev;
      if (xn > 32767 || xn < -32768 || yn > 32767 || yn < -32768 || zn > 32767 || zn < -32768) ov = 1;
      x = xn[15:0]; y = yn[15:0]; z = zn[15:0];
    end
    e.x = x; e.y = y; e.z = z; e.ovf = ov; e.err = 0; e.steps = sh.size();
  endtask

  task automatic issue(input logic signed [15:0] x, y, z, input logic md, input logic [1:0] sys,
                       input int hold, input bit push,
                       input int rx, tx, ry, ty, rz, tz, rovf);
    exp_t e;
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got 0 expected 1");
      return;
    end
    model(x, y, z, md, sys, e);
    e.hold = hold; e.exp_cyc = cyc + 1 + e.steps;
    e.rx = rx; e.tx = tx; e.ry = ry; e.ty = ty; e.rz = rz; e.tz = tz; e.rovf = rovf;
    x_in = x; y_in = y; z_in = z; mode_bit = md; coordinate_system = sys; in_valid = 1;
    if (push) begin
      sb.push_back(e);
      n_pushed++;
    end
    @(negedge clk);
    in_valid = 0;
    x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
    mode_bit = ~md; coordinate_system = 2'($urandom);
  endtask

  // monitor: checks each result when it appears, then completes the output handshake
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1;
        hold_left = 0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid got 1 expected 0");
        end else begin
          me = sb.pop_front();
          chk("latency_cycle", cyc, me.exp_cyc);
          chk("x_out", x_out, me.x);
          chk("y_out", y_out, me.y);
          chk("z_out", z_out, me.z);
          chk("out_ovf", out_ovf, me.ovf);
          chk("out_err", out_err, me.err);
          if (me.tx >= 0) chk_tol("ref_x", x_out, me.rx, me.tx);
          if (me.ty >= 0) chk_tol("ref_y", y_out, me.ry, me.ty);
          if (me.tz >= 0) chk_tol("ref_z", z_out, me.rz, me.tz);
          if (me.rovf >= 0) chk("ref_ovf", out_ovf, me.rovf);
          hold_left = me.hold;
        end
      end
      if (seen) begin
        if (hold_left > 0) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_in_ready", in_ready, 0);
          chk("hold_x", x_out, me.x);
          chk("hold_z", z_out, me.z);
          hold_left--;
        end else if (!out_ready) begin
          out_ready = 1;
        end else begin
          out_ready = 0;
          seen = 0;
          n_done++;
          chk("post_hs_valid", out_valid, 0);
          chk("post_hs_in_ready", in_ready, 1);
        end
      end
    end
  end

  initial begin
    int w;
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    #1 chk("in_ready_after_rst", in_ready, 1);

    // circular rotation by pi/4 with 1/K prescale
    issue(16'h09B7, 16'h0000, 16'h0C91, 0, CIRC, 0, 1, 'h0B50, 4, 'h0B50, 4, 0, 4, 0);
    // circular vectoring, output held for 10 cycles
    issue(16'h1000, 16'h1000, 16'h0000, 1, CIRC, 10, 1, 'h2543, 6, 0, 4, 'h0C91, 4, 0);
    issue(16'h1800, 16'h0000, 16'h0800, 0, LIN, 0, 1, 0, -1, 'h0C00, 2, 0, -1, 0);
    issue(16'h2000, 16'h1000, 16'h0000, 1, LIN, 0, 1, 0, -1, 0, -1, 'h0800, 2, 0);
    issue(16'h1352, 16'h0000, 16'h0800, 0, HYP, 0, 1, 'h120B, 6, 'h0856, 6, 0, -1, 0);
    issue(16'h1234, 16'hABCD, 16'h0F0F, 0, RSVD, 0, 1,
          'h1234, 0, int'(16'shABCD), 0, 'h0F0F, 0, 0);
    issue(16'h7000, 16'h7000, 16'h0000, 1, CIRC, 0, 1, 0, -1, 0, -1, 0, -1, 1);
    issue(16'h1800, 16'h0800, 16'h0000, 1, HYP, 0, 1, 0, -1, 0, -1, 'h058C, 8, 0);
    issue(16'h09B7, 16'h0000, 16'hF36F, 0, CIRC, 0, 1, 'h0B50, 6, -'h0B50, 6, 0, 6, 0);

    // reset in the middle of an operation
    issue(16'h1000, 16'h0000, 16'h0400, 0, CIRC, 0, 0, 0, -1, 0, -1, 0, -1, -1);
    repeat (4) @(negedge clk);
    chk("busy_mid_run", busy, 1);
    rst = 1;
    #1 chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_x", x_out, 0);
    chk("mid_rst_y", y_out, 0);
    chk("mid_rst_z", z_out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 0;
    #1 chk("mid_rst_in_ready_after", in_ready, 1);
    repeat (20) @(negedge clk);
    chk("mid_rst_no_output", out_valid, 0);

    issue(16'h1800, 16'h0000, 16'h0800, 0, LIN, 0, 1, 0, -1, 'h0C00, 2, 0, -1, 0);

    w = 0;
    while ((sb.size() != 0 || seen) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
    end
    chk("result_count", n_done, n_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
